// File: rtl/reg_dump_unit_pkg.sv
// reg_dump_unit_pkg: shared FSM encoding, sync byte and register index width.
package reg_dump_unit_pkg;
    localparam int REG_IDX_W = 5;
    localparam logic [7:0] REG_DUMP_SYNC_BYTE = 8'hA5;
    typedef enum logic [2:0] {ST_IDLE, ST_HEADER, ST_LOAD, ST_SEND, ST_DONE} state_t;
endpackage

// File: rtl/reg_dump_unit_if.sv
// reg_dump_unit_if: start request, bank debug read port and byte stream to UART TX.
// slave modport faces the dump unit, master modport faces the host/bank/UART side.
interface reg_dump_unit_if
    import reg_dump_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
);
    logic                  i_start;
    logic [DATA_WIDTH-1:0] i_reg_data;
    logic                  i_tx_ready;
    logic [REG_IDX_W-1:0]  o_reg_addr;
    logic [7:0]            o_tx_data;
    logic                  o_tx_valid;
    logic                  o_busy;
    logic                  o_done;
    modport slave (
        input  i_start, i_reg_data, i_tx_ready,
        output o_reg_addr, o_tx_data, o_tx_valid, o_busy, o_done
    );
    modport master (
        output i_start, i_reg_data, i_tx_ready,
        input  o_reg_addr, o_tx_data, o_tx_valid, o_busy, o_done
    );
endinterface

// File: rtl/reg_dump_unit_word_serializer.sv
// reg_dump_unit_word_serializer: sends one loaded word MSB byte first over valid/ready.
// Ports: i_clock/i_reset, i_load + i_data (capture word), i_ready (sink accepts),
// o_valid/o_data (byte stream), o_last (final byte of the word accepted this cycle).
module reg_dump_unit_word_serializer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [7:0]            o_data,
    output logic                  o_last
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int CW = BYTES > 1 ? $clog2(BYTES) : 1;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]         byte_cnt_q, byte_cnt_d;
    logic                  valid_q, valid_d;
    logic                  accept;
    assign accept  = valid_q & i_ready;
    assign o_last  = accept && byte_cnt_q == CW'(BYTES - 1);
    assign o_valid = valid_q;
    assign o_data  = shift_q[DATA_WIDTH-1 -: 8];
    always_comb begin
        shift_d    = i_load ? i_data : accept ? shift_q << 8 : shift_q;
        byte_cnt_d = i_load ? '0 : accept ? (o_last ? '0 : byte_cnt_q + 1'b1) : byte_cnt_q;
        valid_d    = i_load ? 1'b1 : o_last ? 1'b0 : valid_q;
    end
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            shift_q    <= '0;
            byte_cnt_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            valid_q    <= valid_d;
        end
    end
endmodule

// File: rtl/reg_dump_unit.sv
// reg_dump_unit: on start, dumps registers 0..NUM_REGS-1 MSB byte first onto a byte stream.
// Ports: i_clock, i_reset (async, active-high), bus (reg_dump_unit_if.slave: start,
// bank debug read, UART TX valid/ready, busy/done status).
// Build option: define REG_DUMP_HEADER_EN to prefix each dump with the sync byte.
module reg_dump_unit
    import reg_dump_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input logic           i_clock,
    input logic           i_reset,
    reg_dump_unit_if.slave bus
);
    localparam logic [REG_IDX_W-1:0] LAST_REG = REG_IDX_W'(NUM_REGS - 1);
    state_t               state_q, state_d;
    logic [REG_IDX_W-1:0] reg_cnt_q, reg_cnt_d;
    logic                 load, hdr, ser_valid, ser_last;
    logic [7:0]           ser_data;
`ifdef REG_DUMP_HEADER_EN
    assign hdr = state_q == ST_HEADER;
`else
    assign hdr = 1'b0;
`endif
    reg_dump_unit_word_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_load  (load),
        .i_data  (bus.i_reg_data),
        .i_ready (bus.i_tx_ready),
        .o_valid (ser_valid),
        .o_data  (ser_data),
        .o_last  (ser_last)
    );
    always_comb begin
        state_d   = state_q;
        reg_cnt_d = reg_cnt_q;
        load      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                reg_cnt_d = '0;
`ifdef REG_DUMP_HEADER_EN
                if (bus.i_start) state_d = ST_HEADER;
`else
                if (bus.i_start) state_d = ST_LOAD;
`endif
            end
`ifdef REG_DUMP_HEADER_EN
            ST_HEADER: if (bus.i_tx_ready) state_d = ST_LOAD;
`endif
            ST_LOAD: begin
                load    = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (ser_last) begin
                    state_d   = reg_cnt_q == LAST_REG ? ST_DONE : ST_LOAD;
                    reg_cnt_d = reg_cnt_q == LAST_REG ? reg_cnt_q : reg_cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                reg_cnt_d = '0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            reg_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            reg_cnt_q <= reg_cnt_d;
        end
    end
    // reg_cnt only changes on word boundaries, so it doubles as the held read address.
    assign bus.o_reg_addr = reg_cnt_q;
    assign bus.o_tx_valid = hdr | ser_valid;
    assign bus.o_tx_data  = hdr ? REG_DUMP_SYNC_BYTE : ser_data;
    assign bus.o_busy     = state_q != ST_IDLE;
    assign bus.o_done     = state_q == ST_DONE;
endmodule

// File: tb/tb_reg_dump_unit.sv
// tb_reg_dump_unit: directed checks of the register dump stream, timing and reset.
module tb_reg_dump_unit;
    localparam int DW = 32;
    localparam int NR = 32;
`ifdef REG_DUMP_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int NBYTES = NR * 4 + HDR;
    localparam int LAT = NR * 5 + HDR;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    reg_dump_unit_if #(.DATA_WIDTH(DW)) bus ();
    reg_dump_unit #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );
    assign bus.i_reg_data = {16'h0000, 3'b000, bus.o_reg_addr, 3'b000, bus.o_reg_addr};
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int viol = 0;
    int idle_run = 0;
    int last_gap = 0;
    bit rand_ready = 1'b0;
    logic hold = 1'b0;
    logic [7:0] hold_data = 8'h00;
    logic [7:0] q[$];
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1;
        bus.i_tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    always @(negedge clk) begin
        if (bus.o_tx_valid && bus.i_tx_ready) q.push_back(bus.o_tx_data);
        if (hold && !rst && (!bus.o_tx_valid || bus.o_tx_data !== hold_data)) viol <= viol + 1;
        hold      <= bus.o_tx_valid && !bus.i_tx_ready && !rst;
        hold_data <= bus.o_tx_data;
        if (bus.o_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (!bus.o_busy) idle_run <= idle_run + 1;
        else begin
            if (idle_run != 0) last_gap <= idle_run;
            idle_run <= 0;
        end
    end
    function automatic logic [7:0] exp_byte(input int k);
        int d;
        d = k - HDR;
        if (d < 0) return 8'hA5;
        return (d % 4 >= 2) ? 8'(d / 4) : 8'h00;
    endfunction
    task automatic pulse_start(output int t0);
        @(posedge clk);
        #1 bus.i_start = 1'b1;
        @(posedge clk);
        #1 t0 = cyc;
        bus.i_start = 1'b0;
    endtask
    task automatic wait_done(input int n, input int budget);
        int i;
        i = 0;
        while (done_cnt < n && i < budget) begin
            @(negedge clk);
            #1 i++;
        end
    endtask
    task automatic test_reset;
        bus.i_start = 1'b0;
        #12;
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.o_busy); end
        checks++; if (bus.o_tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.o_tx_valid); end
        checks++; if (bus.o_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.o_done); end
        checks++; if (bus.o_reg_addr !== 5'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", bus.o_reg_addr); end
        checks++; if (bus.o_tx_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", bus.o_tx_data); end
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", bus.o_busy); end
    endtask
    task automatic test_stream;
        int t0, d0;
        d0 = done_cnt;
        q.delete();
        pulse_start(t0);
        wait_done(d0 + 1, 400);
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL stream_done_count got=%0d exp=1", done_cnt - d0); end
        checks++; if (done_cyc - t0 !== LAT) begin errors++; $display("FAIL stream_latency got=%0d exp=%0d", done_cyc - t0, LAT); end
        checks++; if (q.size() !== NBYTES) begin errors++; $display("FAIL stream_count got=%0d exp=%0d", q.size(), NBYTES); end
        for (int k = 0; k < q.size() && k < NBYTES; k++) begin
            checks++; if (q[k] !== exp_byte(k)) begin errors++; $display("FAIL stream_byte[%0d] got=%h exp=%h", k, q[k], exp_byte(k)); end
        end
        repeat (2) @(negedge clk);
        checks++; if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin errors++; $display("FAIL stream_after busy=%b done=%b exp=0,0", bus.o_busy, bus.o_done); end
    endtask
    task automatic test_header;
        logic [7:0] exp0;
        exp0 = HDR == 1 ? 8'hA5 : 8'h00;
        checks++; if (q.size() < 2 || q[0] !== exp0) begin errors++; $display("FAIL header_first got=%h exp=%h", q.size() > 0 ? q[0] : 8'hxx, exp0); end
        checks++; if (q.size() < 2 || q[HDR] !== 8'h00) begin errors++; $display("FAIL header_reg0_msb got=%h exp=00", q.size() > 1 ? q[HDR] : 8'hxx); end
    endtask
    task automatic test_backpressure;
        int t0, d0, v0;
        d0 = done_cnt;
        v0 = viol;
        q.delete();
        rand_ready = 1'b1;
        pulse_start(t0);
        wait_done(d0 + 1, 3000);
        rand_ready = 1'b0;
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL bp_done_count got=%0d exp=1", done_cnt - d0); end
        checks++; if (viol - v0 !== 0) begin errors++; $display("FAIL bp_stability got=%0d violations exp=0", viol - v0); end
        checks++; if (q.size() !== NBYTES) begin errors++; $display("FAIL bp_count got=%0d exp=%0d", q.size(), NBYTES); end
        for (int k = 0; k < q.size() && k < NBYTES; k++) begin
            checks++; if (q[k] !== exp_byte(k)) begin errors++; $display("FAIL bp_byte[%0d] got=%h exp=%h", k, q[k], exp_byte(k)); end
        end
    endtask
    task automatic test_reset_mid;
        int t0, d0, i;
        q.delete();
        pulse_start(t0);
        i = 0;
        while (q.size() < 37 && i < 500) begin
            @(negedge clk);
            #1 i++;
        end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++; if (q.size() !== 37) begin errors++; $display("FAIL mid_accepted got=%0d exp=37", q.size()); end
        checks++; if (bus.o_tx_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", bus.o_tx_valid); end
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", bus.o_busy); end
        checks++; if (bus.o_reg_addr !== 5'd0) begin errors++; $display("FAIL mid_addr got=%0d exp=0", bus.o_reg_addr); end
        checks++; if (bus.o_tx_data !== 8'h00) begin errors++; $display("FAIL mid_data got=%h exp=00", bus.o_tx_data); end
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        q.delete();
        d0 = done_cnt;
        pulse_start(t0);
        wait_done(d0 + 1, 400);
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL mid_restart_done got=%0d exp=1", done_cnt - d0); end
        checks++; if (q.size() !== NBYTES) begin errors++; $display("FAIL mid_restart_count got=%0d exp=%0d", q.size(), NBYTES); end
        checks++; if (q.size() < 8 || q[0] !== exp_byte(0) || q[HDR + 6] !== 8'h01) begin errors++; $display("FAIL mid_restart_head got=%h,%h exp=%h,01", q.size() > 0 ? q[0] : 8'hxx, q.size() > 7 ? q[HDR + 6] : 8'hxx, exp_byte(0)); end
    endtask
    task automatic test_restart_ignored;
        int t0, t1, d0;
        d0 = done_cnt;
        q.delete();
        pulse_start(t0);
        repeat (50) @(negedge clk);
        pulse_start(t1);
        wait_done(d0 + 1, 400);
        repeat (200) @(negedge clk);
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL ignore_done_count got=%0d exp=1", done_cnt - d0); end
        checks++; if (q.size() !== NBYTES) begin errors++; $display("FAIL ignore_count got=%0d exp=%0d", q.size(), NBYTES); end
        checks++; if (done_cyc - t0 !== LAT) begin errors++; $display("FAIL ignore_latency got=%0d exp=%0d", done_cyc - t0, LAT); end
    endtask
    task automatic test_back_to_back;
        int d0;
        d0 = done_cnt;
        q.delete();
        @(posedge clk);
        #1 bus.i_start = 1'b1;
        wait_done(d0 + 2, 800);
        @(posedge clk);
        #1 bus.i_start = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (done_cnt - d0 !== 2) begin errors++; $display("FAIL b2b_done_count got=%0d exp=2", done_cnt - d0); end
        checks++; if (last_gap !== 1) begin errors++; $display("FAIL b2b_idle_gap got=%0d exp=1", last_gap); end
        checks++; if (q.size() !== 2 * NBYTES) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", q.size(), 2 * NBYTES); end
        for (int k = 0; k < q.size() && k < 2 * NBYTES; k++) begin
            checks++; if (q[k] !== exp_byte(k % NBYTES)) begin errors++; $display("FAIL b2b_byte[%0d] got=%h exp=%h", k, q[k], exp_byte(k % NBYTES)); end
        end
    endtask
    initial begin
        bus.i_start = 1'b0;
        test_reset;
        test_stream;
        test_header;
        test_backpressure;
        test_reset_mid;
        test_restart_ignored;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
